// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU: a valid/ready request in, a held result out; shifts iterate 1 bit/cycle
// unless ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [4:0]        shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              ill_q, ill_d;
`ifndef ALU_FAST_SHIFT_EN
  logic [4:0]        cnt_q, cnt_d;
  logic              dir_q, dir_d;
`endif

  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              alu_ovf, alu_ill, is_shift, shift_right;

  assign sum         = src_a + src_b;
  assign diff        = src_a - src_b;
  assign shift_right = alu_control[0];

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (alu_control)
      4'b0000, 4'b0001: is_shift = 1'b1;
      4'b0010: begin
        alu_res = sum;
        alu_ovf = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
      end
      4'b0011: alu_res = sum;
      4'b0100: begin
        alu_res = diff;
        alu_ovf = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);
      end
      4'b0101: alu_res = diff;
      4'b0110: alu_res = src_a & src_b;
      4'b0111: alu_res = src_a | src_b;
      4'b1000: alu_res = src_a ^ src_b;
      4'b1001: alu_res = ~(src_a | src_b);
      4'b1010: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1011: alu_res = {{(DATA_W-1){1'b0}}, (src_a < src_b)};
      4'b1100: alu_res = {{(DATA_W-1){1'b0}}, (src_a == src_b)};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d    = cnt_q;
    dir_d    = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ovf_d = 1'b0;
          ill_d = 1'b0;
          if (is_shift) begin
`ifdef ALU_FAST_SHIFT_EN
            result_d = shift_right ? (src_b >> shamt) : (src_b << shamt);
            state_d  = DONE;
`else
            // The accept edge performs the first one-bit step, so k shifts finish on edge k.
            result_d = shift_right ? {1'b0, src_b[MSB:1]} : {src_b[MSB-1:0], 1'b0};
            if (shamt == 5'd0) begin
              result_d = src_b;
              state_d  = DONE;
            end else if (shamt == 5'd1) begin
              state_d = DONE;
            end else begin
              state_d = SHIFT;
              cnt_d   = shamt - 5'd1;
              dir_d   = shift_right;
            end
`endif
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            ill_d    = alu_ill;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
`ifdef ALU_FAST_SHIFT_EN
        state_d = IDLE;
`else
        result_d = dir_q ? {1'b0, result_q[MSB:1]} : {result_q[MSB-1:0], 1'b0};
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != IDLE) zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q    <= 5'd0;
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency, hold and reset-abort checks.
module tb_alu_exec_unit;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  alu_control;
  logic [31:0] src_a, src_b, result;
  logic [4:0]  shamt;
  logic        zero, overflow, illegal;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, measure cycles to out_valid, check outputs, then consume the result.
  task automatic do_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_res,
                       input logic exp_z, input logic exp_o, input logic exp_i, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    alu_control = code; src_a = a; src_b = b; shamt = sh; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_flags"}, {29'd0, exp_z, exp_o, exp_i}, {29'd0, exp_z, exp_o, exp_i} ^
          ({29'd0, exp_z, exp_o, exp_i} ^ {29'd0, zero, overflow, illegal}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 4'd0; src_a = '0; src_b = '0; shamt = '0;
    tick();
    tick();
    check("reset_outs", {27'd0, out_valid, zero, overflow, illegal, in_ready}, 32'd1);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_rdy", {31'd0, in_ready}, 32'd1);

    do_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
    do_op("addu",     4'b0011, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1);
    do_op("subu",     4'b0101, 32'h0, 32'h1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1);
    do_op("sub_ovf",  4'b0100, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
    do_op("add_zero", 4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    do_op("and",      4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1);
    do_op("or",       4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1);
    do_op("xor",      4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1);
    do_op("nor",      4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h000F_000F, 1'b0, 1'b0, 1'b0, 1);
    do_op("slt",      4'b1010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0, 1);
    do_op("sltu",     4'b1011, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    do_op("seq",      4'b1100, 32'h5, 32'h5, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0, 1);
    do_op("sll31",    4'b0000, 32'hDEAD_BEEF, 32'h1, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, FAST ? 1 : 31);
    do_op("srl4",     4'b0001, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, FAST ? 1 : 4);
    do_op("sll0",     4'b0000, 32'h0, 32'h0000_1234, 5'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1);
    do_op("srl1",     4'b0001, 32'h0, 32'h3, 5'd1, 32'h1, 1'b0, 1'b0, 1'b0, 1);
    do_op("srl5_z",   4'b0001, 32'h0, 32'hF, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0, FAST ? 1 : 5);
    do_op("ill_1111", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1);
    do_op("ill_1101", 4'b1101, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1);

    // Result must hold while the consumer stalls, and stray requests must be ignored.
    alu_control = 4'b0010; src_a = 32'd2; src_b = 32'd3; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      alu_control = 4'b0110; src_a = 32'hFFFF_0000 + i; src_b = 32'h0; in_valid = 1'b1;
      tick();
      check("hold_res", result, 32'd5);
      check("hold_hs", {30'd0, in_ready, out_valid}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release", {30'd0, in_ready, out_valid}, 32'd2);

    // Reset in the middle of a long right shift must drop the operation entirely.
    alu_control = 4'b0001; src_a = 32'h0; src_b = 32'hFFFF_FFFF; shamt = 5'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_async", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_rdy", {30'd0, in_ready, out_valid}, 32'd2);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("rst_no_stale", seen, 0);
    do_op("after_rst", 4'b0011, 32'h1, 32'h1, 5'd0, 32'h2, 1'b0, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port alu_control  input  4  operation code, sampled on accept.
REQ-007 SHALL have port src_a, src_b  input  32 each  operands, sampled on accept.
REQ-008 SHALL have port shamt  input  5  shift amount, sampled on accept.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  32  operation result.
REQ-012 SHALL have ports zero, overflow, illegal  output  1 each  status flags, valid with out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-014 SHALL accept a request on a rising edge with in_valid=1 in IDLE, capturing all inputs.
REQ-015 SHALL decode codes: 0000 sll, 0001 srl, 0010 add, 0011 addu, 0100 sub, 0101 subu, 0110 and, 0111 or, 1000 xor, 1001 nor, 1010 slt, 1011 sltu, 1100 seq.
REQ-016 SHALL shift src_b by shamt for sll/srl (logical, zero fill); src_a ignored.
REQ-017 SHALL for non-shift codes, and shifts with shamt=0, go IDLE->DONE on the accept edge (out_valid one cycle after accept).
REQ-018 SHALL for shifts with shamt=k>0 go IDLE->SHIFT, shift one bit per cycle, and enter DONE on the k-th edge after accept.
REQ-019 SHALL compute add/sub/addu/subu modulo 2^32; overflow=1 only for add/sub signed overflow, result still the wrapped sum.
REQ-020 SHALL set result to 1/0 for slt (signed), sltu (unsigned), seq (src_a==src_b).
REQ-021 SHALL set zero=1 when result==0.
REQ-022 SHALL treat codes 1101-1111 as illegal: result=0, illegal=1, overflow=0, DONE after one cycle.
REQ-023 SHALL hold result and flags stable in DONE until out_ready=1, then return to IDLE on that edge.
REQ-024 SHALL not accept a new request in the DONE->IDLE cycle (in_ready low in DONE); back-to-back throughput is one op per two cycles minimum.
REQ-025 SHALL ignore in_valid and input changes while in SHIFT or DONE.

Reset
REQ-026 SHALL on rst=1, immediately and asynchronously: state=IDLE, result=0, zero=0, overflow=0, illegal=0, out_valid=0, shift counter=0.
REQ-027 SHALL abandon any in-progress shift or unconsumed result on reset mid-operation; no result is delivered.
REQ-028 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL use macro ALU_FAST_SHIFT_EN to select shifter implementation.
REQ-030 SHALL, with ALU_FAST_SHIFT_EN defined, perform sll/srl in one cycle via barrel shifter (IDLE->DONE, SHIFT state unused).
REQ-031 SHALL, without ALU_FAST_SHIFT_EN, use the iterative shifter of REQ-018; results identical in both builds.

Verification
REQ-032 SHALL cover: add, a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, out_valid one cycle after accept.
REQ-033 SHALL cover: addu same operands -> result 0x80000000, overflow=0; subu a=0, b=1 -> 0xFFFFFFFF, overflow=0.
REQ-034 SHALL cover: sll b=0x00000001, shamt=31 -> result 0x80000000; out_valid 31 cycles after accept (1 cycle with ALU_FAST_SHIFT_EN).
REQ-035 SHALL cover: slt a=0xFFFFFFFF, b=1 -> 1; sltu same -> 0, zero=1; seq a=b=5 -> 1.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0, new in_valid ignored; code 1111 -> illegal=1, result 0.
REQ-037 SHALL cover: rst pulsed during srl shamt=20 at cycle 10 -> out_valid=0, in_ready=1 after release, no stale result.
